// File: rtl/alu_ctrl_decode_stage.sv
// ID-stage ALU/control decoder registered into the ID/EX boundary, with a saturating illegal-instruction counter.
// Optional andi/ori support (zero-extended immediate) is enabled by defining ALU_DECODE_LOGIC_IMM_EN.
module alu_ctrl_decode_stage #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_id,
    input  logic             valid_id,
    input  logic             stall,
    input  logic             flush,
    output logic [2:0]       alu_ctrl_ex,
    output logic             alu_src_ex,
    output logic [31:0]      imm_ex,
    output logic             reg_write_ex,
    output logic             reg_dst_ex,
    output logic             mem_read_ex,
    output logic             mem_write_ex,
    output logic             mem_to_reg_ex,
    output logic             branch_ex,
    output logic             valid_ex,
    output logic             illegal_ex,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef ALU_DECODE_LOGIC_IMM_EN
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [2:0]  dec_alu_ctrl;
    logic        dec_alu_src;
    logic        dec_reg_write;
    logic        dec_reg_dst;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_mem_to_reg;
    logic        dec_branch;
    logic        dec_illegal;
    logic [31:0] dec_imm;

    assign op = instr_id[31:26];
    assign fn = instr_id[5:0];

    always_comb begin
        dec_alu_ctrl   = ALU_ADD;
        dec_alu_src    = 1'b0;
        dec_reg_write  = 1'b0;
        dec_reg_dst    = 1'b0;
        dec_mem_read   = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_branch     = 1'b0;
        dec_illegal    = 1'b0;
        dec_imm        = {{16{instr_id[15]}}, instr_id[15:0]};
        unique case (op)
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                dec_reg_dst   = 1'b1;
                unique case (fn)
                    FN_ADD:  dec_alu_ctrl = ALU_ADD;
                    FN_SUB:  dec_alu_ctrl = ALU_SUB;
                    FN_AND:  dec_alu_ctrl = ALU_AND;
                    FN_OR:   dec_alu_ctrl = ALU_OR;
                    FN_SLT:  dec_alu_ctrl = ALU_SLT;
                    default: begin
                        dec_reg_write = 1'b0;
                        dec_reg_dst   = 1'b0;
                        dec_illegal   = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dec_alu_src    = 1'b1;
                dec_reg_write  = 1'b1;
                dec_mem_read   = 1'b1;
                dec_mem_to_reg = 1'b1;
            end
            OP_SW: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_alu_ctrl = ALU_SUB;
                dec_branch   = 1'b1;
            end
            OP_ADDI: begin
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
            end
`ifdef ALU_DECODE_LOGIC_IMM_EN
            // Logical immediates take an unsigned (zero-extended) operand.
            OP_ANDI: begin
                dec_alu_ctrl  = ALU_AND;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_imm       = {16'b0, instr_id[15:0]};
            end
            OP_ORI: begin
                dec_alu_ctrl  = ALU_OR;
                dec_alu_src   = 1'b1;
                dec_reg_write = 1'b1;
                dec_imm       = {16'b0, instr_id[15:0]};
            end
`endif
            default: dec_illegal = 1'b1;
        endcase
        if (!valid_id) begin
            dec_alu_ctrl  = ALU_ADD;
            dec_alu_src   = 1'b0;
            dec_reg_write = 1'b0;
            dec_reg_dst   = 1'b0;
            dec_mem_read  = 1'b0;
            dec_mem_write = 1'b0;
            dec_mem_to_reg = 1'b0;
            dec_branch    = 1'b0;
            dec_illegal   = 1'b0;
        end
    end

    // Priority: reset, then flush (bubble), then stall (hold), else load.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            alu_ctrl_ex   <= ALU_ADD;
            alu_src_ex    <= 1'b0;
            imm_ex        <= 32'b0;
            reg_write_ex  <= 1'b0;
            reg_dst_ex    <= 1'b0;
            mem_read_ex   <= 1'b0;
            mem_write_ex  <= 1'b0;
            mem_to_reg_ex <= 1'b0;
            branch_ex     <= 1'b0;
            valid_ex      <= 1'b0;
            illegal_ex    <= 1'b0;
        end else if (!stall) begin
            alu_ctrl_ex   <= dec_alu_ctrl;
            alu_src_ex    <= dec_alu_src;
            imm_ex        <= dec_imm;
            reg_write_ex  <= dec_reg_write;
            reg_dst_ex    <= dec_reg_dst;
            mem_read_ex   <= dec_mem_read;
            mem_write_ex  <= dec_mem_write;
            mem_to_reg_ex <= dec_mem_to_reg;
            branch_ex     <= dec_branch;
            valid_ex      <= valid_id;
            illegal_ex    <= dec_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            illegal_cnt <= '0;
        end else if (!flush && !stall && dec_illegal && illegal_cnt != {CNT_W{1'b1}}) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Directed self-checking bench for alu_ctrl_decode_stage; a second instance with CNT_W=2 checks counter saturation.
// Expectations for andi/ori follow ALU_DECODE_LOGIC_IMM_EN when it is defined for the build.
module tb_alu_ctrl_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        stall;
    logic        flush;

    logic [2:0]  alu_ctrl_ex;
    logic        alu_src_ex;
    logic [31:0] imm_ex;
    logic        reg_write_ex;
    logic        reg_dst_ex;
    logic        mem_read_ex;
    logic        mem_write_ex;
    logic        mem_to_reg_ex;
    logic        branch_ex;
    logic        valid_ex;
    logic        illegal_ex;
    logic [7:0]  illegal_cnt;

    logic [2:0]  s_alu_ctrl_ex;
    logic        s_alu_src_ex;
    logic [31:0] s_imm_ex;
    logic        s_reg_write_ex;
    logic        s_reg_dst_ex;
    logic        s_mem_read_ex;
    logic        s_mem_write_ex;
    logic        s_mem_to_reg_ex;
    logic        s_branch_ex;
    logic        s_valid_ex;
    logic        s_illegal_ex;
    logic [1:0]  s_illegal_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] I_ADD  = 32'h014B4820;
    localparam logic [31:0] I_SUB  = 32'h014B4822;
    localparam logic [31:0] I_AND  = 32'h014B4824;
    localparam logic [31:0] I_OR   = 32'h014B4825;
    localparam logic [31:0] I_SLT  = 32'h014B482A;
    localparam logic [31:0] I_LW   = 32'h8D28FFFC;
    localparam logic [31:0] I_SW   = 32'hAD280004;
    localparam logic [31:0] I_BEQ  = 32'h11090003;
    localparam logic [31:0] I_ILL  = 32'hFC000000;
    localparam logic [31:0] I_ANDI = 32'h3128FFFF;
    localparam logic [31:0] I_ORI  = 32'h3528000F;

    alu_ctrl_decode_stage #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .valid_id(valid_id),
        .stall(stall), .flush(flush),
        .alu_ctrl_ex(alu_ctrl_ex), .alu_src_ex(alu_src_ex), .imm_ex(imm_ex),
        .reg_write_ex(reg_write_ex), .reg_dst_ex(reg_dst_ex),
        .mem_read_ex(mem_read_ex), .mem_write_ex(mem_write_ex),
        .mem_to_reg_ex(mem_to_reg_ex), .branch_ex(branch_ex),
        .valid_ex(valid_ex), .illegal_ex(illegal_ex), .illegal_cnt(illegal_cnt)
    );

    alu_ctrl_decode_stage #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .instr_id(instr_id), .valid_id(valid_id),
        .stall(stall), .flush(flush),
        .alu_ctrl_ex(s_alu_ctrl_ex), .alu_src_ex(s_alu_src_ex), .imm_ex(s_imm_ex),
        .reg_write_ex(s_reg_write_ex), .reg_dst_ex(s_reg_dst_ex),
        .mem_read_ex(s_mem_read_ex), .mem_write_ex(s_mem_write_ex),
        .mem_to_reg_ex(s_mem_to_reg_ex), .branch_ex(s_branch_ex),
        .valid_ex(s_valid_ex), .illegal_ex(s_illegal_ex), .illegal_cnt(s_illegal_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic v, input logic s,
                                 input logic f, input logic r);
        instr_id = instr;
        valid_id = v;
        stall    = s;
        flush    = f;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b0;
        instr_id = I_ADD;
        valid_id = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;

        applyStimulus(I_ADD, 1, 0, 0, 0);
        applyStimulus(I_ADD, 1, 0, 0, 0);
        checkOutput("reset_alu", {29'b0, alu_ctrl_ex}, 32'h0);
        checkOutput("reset_regwrite", {31'b0, reg_write_ex}, 32'h0);
        checkOutput("reset_regdst", {31'b0, reg_dst_ex}, 32'h0);
        checkOutput("reset_valid", {31'b0, valid_ex}, 32'h0);
        checkOutput("reset_imm", imm_ex, 32'h0);
        checkOutput("reset_cnt", {24'b0, illegal_cnt}, 32'h0);

        applyStimulus(I_ADD, 1, 0, 0, 1);
        checkOutput("add_alu", {29'b0, alu_ctrl_ex}, 32'h0);
        checkOutput("add_regwrite", {31'b0, reg_write_ex}, 32'h1);
        checkOutput("add_regdst", {31'b0, reg_dst_ex}, 32'h1);
        checkOutput("add_valid", {31'b0, valid_ex}, 32'h1);
        applyStimulus(I_SUB, 1, 0, 0, 1);
        checkOutput("sub_alu", {29'b0, alu_ctrl_ex}, 32'h1);
        checkOutput("sub_regwrite", {31'b0, reg_write_ex}, 32'h1);
        applyStimulus(I_AND, 1, 0, 0, 1);
        checkOutput("and_alu", {29'b0, alu_ctrl_ex}, 32'h2);
        checkOutput("and_regdst", {31'b0, reg_dst_ex}, 32'h1);
        applyStimulus(I_OR, 1, 0, 0, 1);
        checkOutput("or_alu", {29'b0, alu_ctrl_ex}, 32'h3);
        checkOutput("or_valid", {31'b0, valid_ex}, 32'h1);
        applyStimulus(I_SLT, 1, 0, 0, 1);
        checkOutput("slt_alu", {29'b0, alu_ctrl_ex}, 32'h5);
        checkOutput("slt_regwrite", {31'b0, reg_write_ex}, 32'h1);
        checkOutput("slt_illegal", {31'b0, illegal_ex}, 32'h0);

        applyStimulus(I_LW, 1, 0, 0, 1);
        checkOutput("lw_alu", {29'b0, alu_ctrl_ex}, 32'h0);
        checkOutput("lw_alusrc", {31'b0, alu_src_ex}, 32'h1);
        checkOutput("lw_memread", {31'b0, mem_read_ex}, 32'h1);
        checkOutput("lw_memtoreg", {31'b0, mem_to_reg_ex}, 32'h1);
        checkOutput("lw_regwrite", {31'b0, reg_write_ex}, 32'h1);
        checkOutput("lw_regdst", {31'b0, reg_dst_ex}, 32'h0);
        checkOutput("lw_imm", imm_ex, 32'hFFFFFFFC);

        applyStimulus(I_SW, 1, 0, 0, 1);
        checkOutput("sw_memwrite", {31'b0, mem_write_ex}, 32'h1);
        checkOutput("sw_regwrite", {31'b0, reg_write_ex}, 32'h0);
        checkOutput("sw_memread", {31'b0, mem_read_ex}, 32'h0);
        checkOutput("sw_alusrc", {31'b0, alu_src_ex}, 32'h1);
        checkOutput("sw_imm", imm_ex, 32'h00000004);

        applyStimulus(I_BEQ, 1, 0, 0, 1);
        checkOutput("beq_alu", {29'b0, alu_ctrl_ex}, 32'h1);
        checkOutput("beq_branch", {31'b0, branch_ex}, 32'h1);
        checkOutput("beq_regwrite", {31'b0, reg_write_ex}, 32'h0);
        checkOutput("beq_imm", imm_ex, 32'h00000003);

        applyStimulus(I_ADD, 0, 0, 0, 1);
        checkOutput("bubble_valid", {31'b0, valid_ex}, 32'h0);
        checkOutput("bubble_regwrite", {31'b0, reg_write_ex}, 32'h0);
        checkOutput("bubble_illegal", {31'b0, illegal_ex}, 32'h0);

        applyStimulus(I_ADD, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(I_SUB, 1, 1, 0, 1);
            checkOutput($sformatf("stall_alu_%0d", i), {29'b0, alu_ctrl_ex}, 32'h0);
            checkOutput($sformatf("stall_valid_%0d", i), {31'b0, valid_ex}, 32'h1);
            checkOutput($sformatf("stall_regdst_%0d", i), {31'b0, reg_dst_ex}, 32'h1);
        end
        applyStimulus(I_LW, 1, 1, 1, 1);
        checkOutput("flush_valid", {31'b0, valid_ex}, 32'h0);
        checkOutput("flush_regwrite", {31'b0, reg_write_ex}, 32'h0);
        checkOutput("flush_memread", {31'b0, mem_read_ex}, 32'h0);
        checkOutput("flush_alusrc", {31'b0, alu_src_ex}, 32'h0);
        checkOutput("flush_imm", imm_ex, 32'h0);

        // Four illegal presentations, the second one stalled: three loads counted.
        applyStimulus(I_ILL, 1, 0, 0, 1);
        checkOutput("ill1_illegal", {31'b0, illegal_ex}, 32'h1);
        checkOutput("ill1_regwrite", {31'b0, reg_write_ex}, 32'h0);
        checkOutput("ill1_cnt", {24'b0, illegal_cnt}, 32'h1);
        applyStimulus(I_ILL, 1, 1, 0, 1);
        checkOutput("ill2_stalled_cnt", {24'b0, illegal_cnt}, 32'h1);
        applyStimulus(I_ILL, 1, 0, 0, 1);
        checkOutput("ill3_cnt", {24'b0, illegal_cnt}, 32'h2);
        applyStimulus(I_ILL, 1, 0, 0, 1);
        checkOutput("ill4_illegal", {31'b0, illegal_ex}, 32'h1);
        checkOutput("ill4_cnt", {24'b0, illegal_cnt}, 32'h3);
        checkOutput("small_cnt_3", {30'b0, s_illegal_cnt}, 32'h3);

        applyStimulus(I_ILL, 1, 1, 1, 1);
        checkOutput("ill_flush_cnt", {24'b0, illegal_cnt}, 32'h3);
        checkOutput("ill_flush_illegal", {31'b0, illegal_ex}, 32'h0);

        for (int i = 0; i < 4; i++) applyStimulus(I_ILL, 1, 0, 0, 1);
        checkOutput("ill_seven_cnt", {24'b0, illegal_cnt}, 32'h7);
        checkOutput("small_cnt_sat", {30'b0, s_illegal_cnt}, 32'h3);

        applyStimulus(I_ADD, 1, 0, 0, 1);
        checkOutput("after_ill_illegal", {31'b0, illegal_ex}, 32'h0);
        checkOutput("after_ill_cnt", {24'b0, illegal_cnt}, 32'h7);

        applyStimulus(I_SUB, 1, 1, 0, 0);
        checkOutput("rst_stall_valid", {31'b0, valid_ex}, 32'h0);
        checkOutput("rst_stall_regwrite", {31'b0, reg_write_ex}, 32'h0);
        checkOutput("rst_stall_cnt", {24'b0, illegal_cnt}, 32'h0);
        checkOutput("rst_stall_small_cnt", {30'b0, s_illegal_cnt}, 32'h0);
        applyStimulus(I_SUB, 1, 1, 0, 1);
        checkOutput("post_rst_hold_valid", {31'b0, valid_ex}, 32'h0);
        checkOutput("post_rst_hold_regdst", {31'b0, reg_dst_ex}, 32'h0);

        applyStimulus(I_ANDI, 1, 0, 0, 1);
`ifdef ALU_DECODE_LOGIC_IMM_EN
        checkOutput("andi_alu", {29'b0, alu_ctrl_ex}, 32'h2);
        checkOutput("andi_alusrc", {31'b0, alu_src_ex}, 32'h1);
        checkOutput("andi_regwrite", {31'b0, reg_write_ex}, 32'h1);
        checkOutput("andi_imm", imm_ex, 32'h0000FFFF);
        checkOutput("andi_illegal", {31'b0, illegal_ex}, 32'h0);
        checkOutput("andi_cnt", {24'b0, illegal_cnt}, 32'h0);
        applyStimulus(I_ORI, 1, 0, 0, 1);
        checkOutput("ori_alu", {29'b0, alu_ctrl_ex}, 32'h3);
        checkOutput("ori_imm", imm_ex, 32'h0000000F);
        checkOutput("ori_illegal", {31'b0, illegal_ex}, 32'h0);
`else
        checkOutput("andi_illegal", {31'b0, illegal_ex}, 32'h1);
        checkOutput("andi_regwrite", {31'b0, reg_write_ex}, 32'h0);
        checkOutput("andi_imm", imm_ex, 32'hFFFFFFFF);
        checkOutput("andi_cnt", {24'b0, illegal_cnt}, 32'h1);
        applyStimulus(I_ORI, 1, 0, 0, 1);
        checkOutput("ori_illegal", {31'b0, illegal_ex}, 32'h1);
        checkOutput("ori_cnt", {24'b0, illegal_cnt}, 32'h2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_decode_stage.md
Name: alu_ctrl_decode_stage

Overview:
- ID-side producer of the 3-bit ALU operation code and EX control bundle; registers decoded controls into the ID/EX pipeline boundary.
- Decodes a 32-bit MIPS instruction (opcode/funct) and holds the result under stall.
- Clears the EX slot to a bubble on flush.
- Counts illegal encodings for debug.

Parameters:
- CNT_W, 8, width of saturating illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-low reset; sampled on rising edge of clk.
- instr_id  in  32  instruction in ID stage.
- valid_id  in  1  instr_id holds a real instruction.
- stall  in  1  hold EX register contents (hazard unit).
- flush  in  1  replace EX slot with bubble (branch taken).
- alu_ctrl_ex  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- alu_src_ex  out  1  1 = B operand is imm_ex.
- imm_ex  out  32  sign-extended instr[15:0].
- reg_write_ex  out  1  writes register file.
- reg_dst_ex  out  1  1 = rd, 0 = rt.
- mem_read_ex  out  1  load.
- mem_write_ex  out  1  store.
- mem_to_reg_ex  out  1  writeback from memory.
- branch_ex  out  1  beq.
- valid_ex  out  1  EX slot holds a real instruction.
- illegal_ex  out  1  EX slot instruction was unrecognised.
- illegal_cnt  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset (rst=0 at edge): all outputs 0, including illegal_cnt. alu_ctrl_ex = 000. Reset overrides stall and flush.
- Decode is combinational on instr_id. Outputs register one cycle later (latency 1).
- Decode table (op = instr[31:26], fn = instr[5:0]):
  - R-type (op 000000), reg_write=1, reg_dst=1, alu_src=0:
    - fn 100000 → alu_ctrl 000 (add)
    - fn 100010 → 001 (sub)
    - fn 100100 → 010 (and)
    - fn 100101 → 011 (or)
    - fn 101010 → 101 (slt)
    - any other fn → illegal
  - lw (op 100011): 000, alu_src=1, reg_write=1, mem_read=1, mem_to_reg=1.
  - sw (op 101011): 000, alu_src=1, mem_write=1.
  - beq (op 000100): 001, branch=1.
  - addi (op 001000): 000, alu_src=1, reg_write=1.
  - Any other op: illegal.
- Illegal decode: all write/mem/branch controls 0, alu_ctrl 000, illegal=1.
- imm_ex = {{16{instr[15]}}, instr[15:0]} for every opcode.
- valid_id=0: decode as bubble, i.e. all controls 0, illegal=0, valid=0.
- Per-edge priority:
  - rst=0 → reset.
  - Else flush=1 → EX register loads bubble (all controls 0, valid_ex=0, illegal_ex=0, imm_ex=0). Flush wins over stall.
  - Else stall=1 → EX register holds all values.
  - Else → load decoded values; valid_ex=valid_id.
- illegal_cnt: increments by 1 on each edge where the EX register loads (not stalled, not flushed, not reset) with valid_id=1 and illegal decode.
  - Saturates at 2^CNT_W−1.
  - No increment on held or flushed cycles.
- Reset asserted mid-stall: clears immediately at that edge; no stale hold afterwards.

Optional Feature:
- Macro ALU_DECODE_LOGIC_IMM_EN.
- Defined:
  - andi (op 001100) → alu_ctrl 010, alu_src=1, reg_write=1.
  - ori (op 001101) → alu_ctrl 011, alu_src=1, reg_write=1.
  - For these two opcodes only, imm_ex is zero-extended ({16'b0, instr[15:0]}).
- Undefined: op 001100 and 001101 decode as illegal; imm_ex is sign-extended for all opcodes.

Test Plan:
- Reset: hold rst=0 two cycles with instr_id=0x014B4820 and valid_id=1 → all outputs 0, illegal_cnt=0.
- R-type sweep: valid_id=1, one per cycle:
  - add 0x014B4820 → alu_ctrl_ex 000, next cycle.
  - sub 0x014B4822 → 001.
  - and 0x014B4824 → 010.
  - or 0x014B4825 → 011.
  - slt 0x014B482A → 101.
  - For all five: reg_write_ex=1, reg_dst_ex=1, valid_ex=1.
- Memory/immediate:
  - lw 0x8D28FFFC → alu_ctrl 000, alu_src 1, mem_read 1, mem_to_reg 1, imm_ex 0xFFFFFFFC.
  - sw 0xAD280004 → mem_write 1, reg_write 0, imm_ex 0x00000004.
  - beq 0x11090003 → alu_ctrl 001, branch 1.
- Stall/flush:
  - Load add; then stall=1 three cycles while instr_id=sub → EX stays add.
  - Assert stall=1 and flush=1 together → next cycle valid_ex=0, all controls 0.
- Illegal: present op 111111 valid four times, with stall=1 on the second presentation → illegal_ex=1 on the loaded cycles; illegal_cnt=3. With CNT_W=2, seven loaded illegal instructions → illegal_cnt=3 (saturated).
- Macro: andi 0x3128FFFF → with ALU_DECODE_LOGIC_IMM_EN: alu_ctrl 010, imm_ex 0x0000FFFF, illegal_ex 0; without it: illegal_ex 1, illegal_cnt increments.
